// File: rtl/decoder_scan.sv
// decoder_scan: registered one-hot decoder with a dwell-timed scan mode
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   rst   - asynchronous active-high reset
//   en    - block enable, 0 forces IDLE
//   mode  - 0 = DECODE, 1 = SCAN (sampled while en=1)
//   load  - in DECODE, capture S on this edge
//   S     - select value to decode
//   Y     - registered one-hot output (2^N bits)
//   valid - Y holds a legal one-hot code
//   idx   - index of the asserted Y bit, 0 when valid=0
// Macro DECODER_SCAN_ACTIVE_LOW_EN: drive Y inverted (one-cold, all-ones when idle/reset).
module decoder_scan #(
  parameter int N     = 2,
  parameter int DWELL = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              mode,
  input  logic              load,
  input  logic [N-1:0]      S,
  output logic [(1<<N)-1:0] Y,
  output logic              valid,
  output logic [N-1:0]      idx
);
  localparam int W  = 1 << N;
  localparam int CW = $clog2(DWELL + 1);
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [W-1:0] OFF = '1;
`else
  localparam logic [W-1:0] OFF = '0;
`endif
  typedef enum logic [1:0] {IDLE, DECODE, SCAN} state_t;
  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [N-1:0]    idx_q;
  logic [N-1:0]    idx_d;
  logic            valid_q;
  logic [W-1:0]    y_q;
  logic            last;
  // idx rolls over naturally in N bits, giving the gapless wrap to 0
  assign idx_d = idx_q + 1'b1;
  assign last  = cnt_q == CW'(DWELL - 1);
  // Y is stored already in output polarity so the pin stays a pure flop output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= OFF;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (!en) begin
      state_q <= IDLE;
      y_q     <= OFF;
      valid_q <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else if (mode) begin
      if (state_q != SCAN) begin
        state_q <= SCAN;
        y_q     <= OFF ^ W'(1);
        valid_q <= 1'b1;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else if (last) begin
        cnt_q <= '0;
        idx_q <= idx_d;
        y_q   <= OFF ^ (W'(1) << idx_d);
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      // entry edge into DECODE never captures S, even with load=1
      if (state_q != DECODE) begin
        state_q <= DECODE;
        y_q     <= OFF;
        valid_q <= 1'b0;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else if (load) begin
        y_q     <= OFF ^ (W'(1) << S);
        idx_q   <= S;
        valid_q <= 1'b1;
      end
    end
  end
  assign Y     = y_q;
  assign valid = valid_q;
  assign idx   = idx_q;
endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 2: select width; output width is 2^N (N >= 1).
REQ-002 Parameter DWELL, default 4: cycles per output position in scan mode (DWELL >= 1).
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  block enable; 0 forces IDLE.
REQ-006 mode  input  1  0 = DECODE, 1 = SCAN; sampled only while en=1.
REQ-007 load  input  1  in DECODE, capture S on this edge.
REQ-008 S  input  N  select value to decode.
REQ-009 Y  output  2^N  registered one-hot output.
REQ-010 valid  output  1  Y holds a legal one-hot code.
REQ-011 idx  output  N  index of the asserted Y bit; 0 when valid=0.

Function
REQ-012 The block SHALL implement the states IDLE, DECODE and SCAN; all outputs SHALL be registered.
REQ-013 Transitions SHALL be:
- IDLE -> DECODE on en=1 & mode=0.
- IDLE -> SCAN on en=1 & mode=1.
- DECODE <-> SCAN on a mode change while en=1.
- Any state -> IDLE on en=0.
- Each transition takes effect at the next rising edge.
REQ-014 In IDLE, the block SHALL drive Y=0, valid=0 and idx=0.
REQ-015 On entering DECODE, the block SHALL drive Y=0 and valid=0 until the first load.
REQ-016 In DECODE, load=1 at edge k SHALL produce Y=1<<S, idx=S and valid=1 after edge k (one-cycle latency).
REQ-017 In DECODE with load=0, Y, idx and valid SHALL hold their values.
REQ-018 In DECODE with S=2^N-1, the block SHALL set the MSB of Y only.
REQ-019 The IDLE -> DECODE edge SHALL NOT capture S, even if load=1 on that edge.
REQ-020 On entering SCAN, the block SHALL set idx=0, Y=1, valid=1 and clear the dwell counter.
REQ-021 In SCAN, the block SHALL hold each idx for exactly DWELL cycles, then increment it.
REQ-022 idx SHALL wrap from 2^N-1 to 0 with no gap cycle; DWELL=1 advances idx every cycle.
REQ-023 In SCAN, the block SHALL ignore load and S.
REQ-024 The dwell counter SHALL be ceil(log2(DWELL+1)) bits wide and SHALL never exceed DWELL-1.
REQ-025 When en=0 and a mode change occur on the same edge, en=0 SHALL take priority (next state IDLE).
REQ-026 When a mode change to DECODE and load=1 occur on the same edge, load SHALL be ignored (REQ-015 applies).
REQ-027 At every cycle boundary, Y SHALL be either all-zero (valid=0) or exactly one-hot (valid=1).

Reset
REQ-028 While rst=1, the block SHALL asynchronously force state=IDLE, Y=0, valid=0, idx=0 and dwell counter=0.
REQ-029 After rst deasserts, the block SHALL leave IDLE no earlier than the first rising edge.
REQ-030 Reset asserted mid-SCAN or mid-DECODE SHALL discard all progress; re-entry to SCAN restarts at idx=0.

Configuration
REQ-031 With macro DECODER_SCAN_ACTIVE_LOW_EN defined, Y SHALL be the bitwise inverse of the one-hot code:
- one-cold when valid=1;
- all-ones in IDLE and under reset.
REQ-032 With DECODER_SCAN_ACTIVE_LOW_EN undefined, Y SHALL be active-high as in REQ-014 to REQ-030.
REQ-033 The macro SHALL NOT affect valid, idx, state or timing.

Verification (N=2, DWELL=3, macro undefined unless stated)
REQ-034 rst=1 mid-scan at idx=2 -> Y=0000, valid=0 immediately; on release with en=1, mode=1 -> Y=0001 at the first edge.
REQ-035 DECODE: load S=00, 01, 10, 11 on consecutive edges -> Y=0001, 0010, 0100, 1000, each one cycle after its load; load=0 -> Y holds 1000.
REQ-036 SCAN for 14 cycles -> Y sequence 0001x3, 0010x3, 0100x3, 1000x3, 0001x2; idx follows 0,1,2,3,0.
REQ-037 Same edge en=0 and mode 0->1 -> IDLE, Y=0000; in DECODE, mode->1 with load=1, S=11 -> SCAN with Y=0001, S ignored.
REQ-038 DWELL=1, N=3 SCAN -> idx advances every cycle; wrap 7->0 with Y 10000000 -> 00000001 and no gap.
REQ-039 DECODER_SCAN_ACTIVE_LOW_EN defined, DECODE load S=10 -> Y=1011, valid=1; in IDLE -> Y=1111.
